// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the processor instruction feeder
//
// Provides the feeder FSM state encoding, the opcode values the feeder
// recognises, the bus data width, and a helper that extracts the opcode
// field from an instruction word.
package proc_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        IMM    = 3'd4,
        WAIT   = 3'd5,
        HALT   = 3'd6
    } state_t;

    // The opcode field occupies the top three bits of an instruction word.
    function automatic logic [2:0] opcode_of(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: 3];
    endfunction

endpackage

// File: rtl/prog_rom.sv
// rtl/prog_rom.sv - synchronous program ROM with a load port, one-cycle read latency
//
// Ports:
//   clk      - clock, read and load happen on the rising edge
//   addr     - read address
//   data     - read data, valid the cycle after addr is presented
//   wr_en    - load strobe used to initialise the contents
//   wr_addr  - load address
//   wr_data  - load data
module prog_rom #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        data <= mem[addr];
    end

endmodule

// File: rtl/proc_feeder.sv
// rtl/proc_feeder.sv - instruction-issuing front end driving the processor DIN/Run/Done interface
//
// Walks a program held in an external synchronous ROM, presents each
// instruction on DIN with a one-cycle Run pulse, supplies the immediate
// word for move-immediate on the following cycle, then waits for Done.
//
// Ports:
//   Clock       - system clock
//   Reset       - synchronous active-high reset
//   Start       - launch program at address 0 (honoured in IDLE/HALT only)
//   MemAddr     - ROM read address (low bits of PC)
//   MemData     - ROM read data, one cycle after MemAddr
//   DIN         - instruction / immediate word to the processor
//   Run         - one-cycle pulse marking a new instruction on DIN
//   Done        - processor instruction-complete strobe
//   Busy        - high from FETCH through WAIT
//   Halted      - high in HALT
//   InstrCount  - instructions completed since Start, saturating
//   WdErr       - watchdog expiry flag (PROC_FEEDER_WATCHDOG_EN only)
//
// Build option PROC_FEEDER_WATCHDOG_EN bounds the WAIT state to WD_CYCLES
// cycles; without it WAIT is unbounded.
module proc_feeder
    import proc_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int PROG_LEN = 32
`ifdef PROC_FEEDER_WATCHDOG_EN
    ,
    parameter int WD_CYCLES = 64
`endif
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic [DATA_W-1:0] InstrCount
`ifdef PROC_FEEDER_WATCHDOG_EN
    ,
    output logic              WdErr
`endif
);

    localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W:0] PC_ONE   = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_next;
    // One extra bit so PC can reach PROG_LEN (even 2**ADDR_W) without wrapping.
    logic [ADDR_W:0]   pc;
    logic [DATA_W-1:0] instr_reg;
    logic [DATA_W-1:0] instr_count;

    logic              start_take;
    logic              done_take;
    logic [ADDR_W:0]   pc_at_done;
    logic              prog_end;
    logic              wd_expire;

    assign start_take = Start && (state == IDLE || state == HALT);
    assign done_take  = Done && (state == IMM || state == WAIT);
    // IMM increments PC on the same edge that may complete the instruction,
    // so the end-of-program test must look at the post-increment value.
    assign pc_at_done = (state == IMM) ? pc + PC_ONE : pc;
    assign prog_end   = (pc_at_done >= PROG_END);

`ifdef PROC_FEEDER_WATCHDOG_EN
    localparam int              WD_W      = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WD_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == WAIT) && !Done && (wd_cnt == WD_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wd_cnt <= '0;
            WdErr  <= 1'b0;
        end else begin
            // Counts WAIT cycles; restarts on every entry to WAIT.
            if (state == WAIT) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end else begin
                wd_cnt <= '0;
            end
            if (start_take) begin
                WdErr <= 1'b0;
            end else if (wd_expire) begin
                WdErr <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = (opcode_of(MemData) == OP_HALT) ? HALT : ISSUE;
            ISSUE:   state_next = (opcode_of(instr_reg) == OP_MVI) ? IMM : WAIT;
            IMM: begin
                if (Done) begin
                    state_next = prog_end ? HALT : FETCH;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (Done) begin
                    state_next = prog_end ? HALT : FETCH;
                end else if (wd_expire) begin
                    state_next = HALT;
                end
            end
            HALT:    if (Start) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        Run    = 1'b0;
        Busy   = 1'b0;
        Halted = 1'b0;
        DIN    = '0;
        case (state)
            FETCH, DECODE: Busy = 1'b1;
            ISSUE: begin
                Busy = 1'b1;
                Run  = 1'b1;
                DIN  = instr_reg;
            end
            IMM: begin
                Busy = 1'b1;
                // ROM was addressed with the incremented PC during ISSUE,
                // so MemData already carries the immediate word.
                DIN  = MemData;
            end
            WAIT: begin
                Busy = 1'b1;
                DIN  = instr_reg;
            end
            HALT:    Halted = 1'b1;
            default: ;
        endcase
    end

    assign MemAddr    = pc[ADDR_W-1:0];
    assign InstrCount = instr_count;

    // Program counter, instruction register and completion counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc          <= '0;
            instr_reg   <= '0;
            instr_count <= '0;
        end else begin
            if (start_take) begin
                pc          <= '0;
                instr_count <= '0;
            end
            if (state == DECODE && opcode_of(MemData) != OP_HALT) begin
                instr_reg <= MemData;
                pc        <= pc + PC_ONE;
            end
            if (state == IMM) begin
                pc <= pc + PC_ONE;
            end
            if (done_take && instr_count != {DATA_W{1'b1}}) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_feeder.sv
// tb/tb_proc_feeder.sv - scoreboard testbench for proc_feeder with a prog_rom program store
module tb_proc_feeder;

    localparam int ADDR_W   = 5;
    localparam int PROG_LEN = 3;

    logic              clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Done;
    logic [ADDR_W-1:0] MemAddr;
    logic [15:0]       MemData;
    logic [15:0]       DIN;
    logic              Run;
    logic              Busy;
    logic              Halted;
    logic [15:0]       InstrCount;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
`ifdef PROC_FEEDER_WATCHDOG_EN
    logic              WdErr;
`endif

    always #5 clk = ~clk;

    proc_feeder #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) dut (
        .Clock      (clk),
        .Reset      (Reset),
        .Start      (Start),
        .MemAddr    (MemAddr),
        .MemData    (MemData),
        .DIN        (DIN),
        .Run        (Run),
        .Done       (Done),
        .Busy       (Busy),
        .Halted     (Halted),
        .InstrCount (InstrCount)
`ifdef PROC_FEEDER_WATCHDOG_EN
        ,
        .WdErr      (WdErr)
`endif
    );

    prog_rom #(.ADDR_W(ADDR_W), .DATA_W(16)) rom (
        .clk     (clk),
        .addr    (MemAddr),
        .data    (MemData),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    typedef struct {
        logic [15:0] din;
        bit          has_imm;
        logic [15:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] din, input bit has_imm, input logic [15:0] imm);
        exp_t e;
        e.din     = din;
        e.has_imm = has_imm;
        e.imm     = imm;
        exp_q.push_back(e);
    endtask

    // One cycle; Start and Done are single-cycle pulses, dropped at each step.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            Start = 1'b0;
            Done  = 1'b0;
        end
    endtask

    // Counts cycles until Run; a missing Run shows up as latency 999.
    task automatic wait_run(input int req_lat, input string name);
        int n    = 0;
        bit seen = 0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (Run) seen = 1;
        end
        chk(name, seen ? n : 999, req_lat);
    endtask

    task automatic rom_write(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Monitor: every Run pops one expected instruction; an mvi also checks
    // the immediate word on DIN the following cycle.
    bit          prev_run    = 0;
    bit          pending_imm = 0;
    logic [15:0] imm_req     = '0;

    always @(negedge clk) begin
        if (Reset) begin
            prev_run    = 0;
            pending_imm = 0;
        end else begin
            if (pending_imm) begin
                chk("imm_din", DIN, imm_req);
                pending_imm = 0;
            end
            if (Run) begin
                chk("run_gap", prev_run, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_run", DIN, 16'hxxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("run_din", DIN, e.din);
                    if (e.has_imm) begin
                        pending_imm = 1;
                        imm_req     = e.imm;
                    end
                end
            end
            prev_run = Run;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Done  = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) rom_write(i, 16'h0000);

        chk("rst_run", Run, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_din", DIN, 16'h0000);
        chk("rst_count", InstrCount, 16'h0000);
        chk("rst_addr", MemAddr, 0);
        Reset = 1'b0;
        step(2);
        chk("idle_busy", Busy, 0);

        // mv then HALT opcode.
        rom_write(0, 16'h0280);
        rom_write(1, 16'hE000);
        push(16'h0280, 0, 0);
        Start = 1'b1;
        wait_run(3, "t1_start_lat");
        step(2);
        Done = 1'b1;
        step();
        chk("t1_count", InstrCount, 1);
        step(2);
        chk("t1_halted", Halted, 1);
        chk("t1_busy", Busy, 0);
        chk("t1_addr", MemAddr, 1);

        // mvi with Done during IMM: straight back to FETCH.
        rom_write(0, 16'h2000);
        rom_write(1, 16'h00A5);
        rom_write(2, 16'hE000);
        push(16'h2000, 1, 16'h00A5);
        Start = 1'b1;
        wait_run(3, "t2_start_lat");
        step();
        Done = 1'b1;
        step();
        chk("t2_fetch_busy", Busy, 1);
        chk("t2_fetch_addr", MemAddr, 2);
        chk("t2_count", InstrCount, 1);
        step(2);
        chk("t2_halted", Halted, 1);

        // PROG_LEN=3 auto-halt without a HALT opcode.
        rom_write(0, 16'h0280);
        rom_write(1, 16'h4000);
        rom_write(2, 16'h6000);
        rom_write(3, 16'hE000);
        push(16'h0280, 0, 0);
        push(16'h4000, 0, 0);
        push(16'h6000, 0, 0);
        Start = 1'b1;
        wait_run(3, "t3_run0");
        step();
        Done = 1'b1;
        wait_run(3, "t3_done_lat1");
        step();
        Done = 1'b1;
        wait_run(3, "t3_done_lat2");
        step();
        Done = 1'b1;
        step();
        chk("t3_halted", Halted, 1);
        chk("t3_count", InstrCount, 3);
        chk("t3_addr", MemAddr, 3);

        // mvi at the last program address reads its immediate from address 3.
        rom_write(2, 16'h2400);
        rom_write(3, 16'h1234);
        push(16'h0280, 0, 0);
        push(16'h4000, 0, 0);
        push(16'h2400, 1, 16'h1234);
        Start = 1'b1;
        wait_run(3, "t4_run0");
        step();
        Done = 1'b1;
        wait_run(3, "t4_run1");
        step();
        Done = 1'b1;
        wait_run(3, "t4_run2");
        step(2);
        Done = 1'b1;
        step();
        chk("t4_halted", Halted, 1);
        chk("t4_count", InstrCount, 3);
        chk("t4_addr", MemAddr, 4);

        // Reset in WAIT, then a clean restart from address 0.
        rom_write(2, 16'h6000);
        push(16'h0280, 0, 0);
        Start = 1'b1;
        wait_run(3, "t5_run0");
        step();
        Done = 1'b1;
        push(16'h4000, 0, 0);
        wait_run(3, "t5_run1");
        step();
        chk("t5_pre_count", InstrCount, 1);
        chk("t5_pre_busy", Busy, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("t5_busy", Busy, 0);
        chk("t5_run", Run, 0);
        chk("t5_count", InstrCount, 0);
        chk("t5_halted", Halted, 0);
        chk("t5_din", DIN, 16'h0000);
        chk("t5_addr", MemAddr, 0);
        step(2);
        chk("t5_idle", Busy, 0);
        push(16'h0280, 0, 0);
        Start = 1'b1;
        wait_run(3, "t5_restart");
        step();
        Done = 1'b1;
        push(16'h4000, 0, 0);
        wait_run(3, "t5_run1b");
        step();
        Done = 1'b1;
        push(16'h6000, 0, 0);
        wait_run(3, "t5_run2b");
        step();
        Done = 1'b1;
        step();
        chk("t5_end_halted", Halted, 1);
        chk("t5_end_count", InstrCount, 3);

        // Start during WAIT and Done during FETCH are both ignored.
        push(16'h0280, 0, 0);
        Start = 1'b1;
        wait_run(3, "t6_run0");
        step();
        Start = 1'b1;
        step();
        chk("t6_wait_busy", Busy, 1);
        chk("t6_wait_count", InstrCount, 0);
        Done = 1'b1;
        step();
        chk("t6_fetch_count", InstrCount, 1);
        Done = 1'b1;
        step();
        chk("t6_decode_count", InstrCount, 1);
        push(16'h4000, 0, 0);
        wait_run(1, "t6_run1");
        step();
        Done = 1'b1;
        push(16'h6000, 0, 0);
        wait_run(3, "t6_run2");
        step();
        Done = 1'b1;
        step();
        chk("t6_halted", Halted, 1);
        chk("t6_count", InstrCount, 3);

        step(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
